// File: rtl/router_input_arbiter.sv
// Multi-input connection-request arbiter: routes each accepted request to an output port
// chosen by its destination address, round-robin per port, with grant hold timeout.
module router_input_arbiter #(
  parameter int N_IN     = 4,
  parameter int N_OUT    = 4,
  parameter int ADDR_W   = 10,
  parameter int HOLD_MAX = 64,
  localparam int IDX_W   = $clog2(N_IN),
  localparam int PSEL_W  = $clog2(N_OUT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN-1:0]          req_valid,
  output logic [N_IN-1:0]          req_ready,
  input  logic [N_IN*ADDR_W-1:0]   req_src_addr,
  input  logic [N_IN*ADDR_W-1:0]   req_dst_addr,
  output logic [N_IN-1:0]          in_granted,
  output logic [N_OUT-1:0]         gnt_valid,
  output logic [N_OUT*IDX_W-1:0]   gnt_in_idx,
  output logic [N_OUT*ADDR_W-1:0]  gnt_src_addr,
  output logic [N_OUT*ADDR_W-1:0]  gnt_dst_addr,
  input  logic [N_OUT-1:0]         out_release,
  output logic [N_OUT-1:0]         timeout
);

  localparam int CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(HOLD_MAX);

  logic [N_IN-1:0]   pending_q;
  logic [N_IN-1:0]   accept;
  logic [N_IN-1:0]   grant_in;
  logic [N_IN-1:0]   in_granted_q;
  logic [ADDR_W-1:0] src_q [N_IN];
  logic [ADDR_W-1:0] dst_q [N_IN];
  logic [PSEL_W-1:0] port_q [N_IN];

  logic [N_OUT-1:0]  gnt_valid_q;
  logic [N_OUT-1:0]  grant_port;
  logic [N_OUT-1:0]  rel;
  logic [N_OUT-1:0]  expire;
  logic [N_OUT-1:0]  timeout_q;
  logic [IDX_W-1:0]  rr_ptr_q [N_OUT];
  logic [IDX_W-1:0]  win_idx  [N_OUT];
  logic [IDX_W-1:0]  win_next [N_OUT];
  logic [IDX_W-1:0]  gnt_idx_q [N_OUT];
  logic [ADDR_W-1:0] gnt_src_q [N_OUT];
  logic [ADDR_W-1:0] gnt_dst_q [N_OUT];
  logic [CNT_W-1:0]  hold_q [N_OUT];

  assign req_ready = ~pending_q;
  assign accept    = req_valid & ~pending_q;

  // Grant selection uses only registered pending/gnt_valid, so a request accepted or a
  // port released at an edge cannot be granted until the following edge.
  always_comb begin
    int idx;
    idx        = 0;
    grant_port = '0;
    grant_in   = '0;
    rel        = '0;
    expire     = '0;
    for (int o = 0; o < N_OUT; o++) begin
      win_idx[o]  = '0;
      win_next[o] = '0;
      rel[o]      = out_release[o] & gnt_valid_q[o];
      expire[o]   = (HOLD_MAX > 0) && gnt_valid_q[o] && (hold_q[o] == CNT_LAST);
      if (!gnt_valid_q[o]) begin
        for (int k = 0; k < N_IN; k++) begin
          idx = (int'(rr_ptr_q[o]) + k) % N_IN;
          if (!grant_port[o] && pending_q[idx] && (port_q[idx] == PSEL_W'(o))) begin
            grant_port[o] = 1'b1;
            win_idx[o]    = IDX_W'(idx);
          end
        end
      end
      win_next[o] = IDX_W'((int'(win_idx[o]) + 1) % N_IN);
      if (grant_port[o]) grant_in[win_idx[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      in_granted_q <= '0;
      gnt_valid_q  <= '0;
      timeout_q    <= '0;
      for (int i = 0; i < N_IN; i++) begin
        src_q[i]  <= '0;
        dst_q[i]  <= '0;
        port_q[i] <= '0;
      end
      for (int o = 0; o < N_OUT; o++) begin
        rr_ptr_q[o]  <= '0;
        gnt_idx_q[o] <= '0;
        gnt_src_q[o] <= '0;
        gnt_dst_q[o] <= '0;
        hold_q[o]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (accept[i]) begin
          pending_q[i] <= 1'b1;
          src_q[i]     <= req_src_addr[i*ADDR_W +: ADDR_W];
          dst_q[i]     <= req_dst_addr[i*ADDR_W +: ADDR_W];
          port_q[i]    <= req_dst_addr[i*ADDR_W +: PSEL_W];
        end else if (grant_in[i]) begin
          pending_q[i] <= 1'b0;
        end
      end
      in_granted_q <= grant_in;
      for (int o = 0; o < N_OUT; o++) begin
        // A release on the expiry edge takes precedence and suppresses the pulse.
        timeout_q[o] <= expire[o] & ~rel[o];
        if (grant_port[o]) begin
          gnt_valid_q[o] <= 1'b1;
          gnt_idx_q[o]   <= win_idx[o];
          gnt_src_q[o]   <= src_q[win_idx[o]];
          gnt_dst_q[o]   <= dst_q[win_idx[o]];
          rr_ptr_q[o]    <= win_next[o];
          hold_q[o]      <= '0;
        end else if (gnt_valid_q[o]) begin
          if (rel[o] || expire[o]) begin
            gnt_valid_q[o] <= 1'b0;
            hold_q[o]      <= '0;
          end else if ((HOLD_MAX > 0) && (hold_q[o] != CNT_SAT)) begin
            hold_q[o] <= hold_q[o] + 1'b1;
          end
        end
      end
    end
  end

  assign in_granted = in_granted_q;
  assign gnt_valid  = gnt_valid_q;
  assign timeout    = timeout_q;

  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    assign gnt_in_idx[o*IDX_W +: IDX_W]     = gnt_idx_q[o];
    assign gnt_src_addr[o*ADDR_W +: ADDR_W] = gnt_src_q[o];
    assign gnt_dst_addr[o*ADDR_W +: ADDR_W] = gnt_dst_q[o];
  end

endmodule
